// File: rtl/mod_exp_sequencer.sv
// Operand sequencer and result capture around modular_exp.
// Accepts one (M, D, N) job, holds the core in reset for a settle window,
// releases it while trigger marks the capture window, then presents the
// captured result (or a timeout/error status) until downstream takes it.
module mod_exp_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_m,
  input  logic [WIDTH-1:0] in_d,
  input  logic [WIDTH-1:0] in_n,
  output logic             exp_reset,
  output logic [WIDTH-1:0] exp_m,
  output logic [WIDTH-1:0] exp_d,
  output logic [WIDTH-1:0] exp_n,
  input  logic [WIDTH-1:0] exp_result,
  input  logic             exp_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_timeout,
  output logic             out_error,
  output logic             trigger,
  output logic             busy
);

  // One counter serves both the settle window and the run timeout.
  localparam int unsigned CntMax = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] LoadLast = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] RunLast  = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StHold} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d, d_q, d_d, n_q, n_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             timeout_q, timeout_d;
  logic             error_q, error_d;

  // State, counter, operand and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      m_q       <= '0;
      d_q       <= '0;
      n_q       <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      d_q       <= d_d;
      n_q       <= n_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      error_q   <= error_d;
    end
  end

  // Next-state, counter and capture logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    d_d       = d_q;
    n_d       = n_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    error_d   = error_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          m_d       = in_m;
          d_d       = in_d;
          n_d       = in_n;
          result_d  = '0;
          timeout_d = 1'b0;
          error_d   = 1'b0;
          cnt_d     = '0;
          if (in_n == '0) begin
            // Modulus zero is rejected without ever releasing the core.
            error_d = 1'b1;
            state_d = StHold;
          end else if (in_n == WIDTH'(1)) begin
            // Anything mod 1 is 0, so bypass the core.
            state_d = StHold;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (cnt_q == LoadLast) begin
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        // Done takes priority over a coincident timeout.
        if (exp_done) begin
          result_d = exp_result;
          state_d  = StHold;
        end else if (cnt_q == RunLast) begin
          result_d  = '0;
          timeout_d = 1'b1;
          state_d   = StHold;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake and core-control outputs decoded from state only.
  always_comb begin
    in_ready  = (state_q == StIdle);
    exp_reset = (state_q != StRun);
    trigger   = (state_q == StRun);
    out_valid = (state_q == StHold);
    busy      = (state_q != StIdle);
  end

  assign exp_m       = m_q;
  assign exp_d       = d_q;
  assign exp_n       = n_q;
  assign out_result  = result_q;
  assign out_timeout = timeout_q;
  assign out_error   = error_q;

endmodule

// File: tb/tb_mod_exp_sequencer.sv
// Bench for mod_exp_sequencer: behavioural core stub with per-job latency,
// queue-based scoreboard and a monitor that checks every delivered result.
module tb_mod_exp_sequencer;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned RST_CYCLES = 4;
  localparam int unsigned TIMEOUT    = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_m, in_d, in_n;
  logic             exp_reset;
  logic [WIDTH-1:0] exp_m, exp_d, exp_n, exp_result;
  logic             exp_done;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_timeout, out_error, trigger, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mod_exp_sequencer #(
    .WIDTH     (WIDTH),
    .RST_CYCLES(RST_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_m       (in_m),
    .in_d       (in_d),
    .in_n       (in_n),
    .exp_reset  (exp_reset),
    .exp_m      (exp_m),
    .exp_d      (exp_d),
    .exp_n      (exp_n),
    .exp_result (exp_result),
    .exp_done   (exp_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_timeout(out_timeout),
    .out_error  (out_error),
    .trigger    (trigger),
    .busy       (busy)
  );

  // Plain square-and-multiply modular exponentiation.
  function automatic logic [31:0] modexp(logic [31:0] m, logic [31:0] d, logic [31:0] n);
    longint unsigned r, b, md;
    if (n == 0) return 32'd0;
    md = longint'(n);
    r  = 1 % md;
    b  = longint'(m) % md;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) r = (r * b) % md;
      b = (b * b) % md;
    end
    return r[31:0];
  endfunction

  // Core stub: done pulses after core_lat released cycles; garbage otherwise.
  int unsigned core_lat = 1000;
  int unsigned run_cnt  = 0;
  always @(posedge clk) begin
    if (exp_reset) run_cnt <= 0;
    else           run_cnt <= run_cnt + 1;
  end
  assign exp_done   = !exp_reset && (run_cnt == core_lat - 1);
  assign exp_result = exp_done ? modexp(exp_m, exp_d, exp_n) : 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] result;
    logic        timeout;
    logic        error;
    int          latency;
    int          trig;
    int          acc;
  } exp_t;

  exp_t sb[$];

  // Expected response of one job from the job inputs and the core latency.
  function automatic exp_t model(logic [31:0] m, logic [31:0] d, logic [31:0] n,
                                 int unsigned lat, int acc);
    exp_t e;
    e.result = 0; e.timeout = 0; e.error = 0; e.latency = 0; e.trig = 0; e.acc = acc;
    if (n == 0) begin
      e.error = 1;
    end else if (n == 1) begin
      e.result = 0;
    end else if (lat <= TIMEOUT) begin
      e.result  = modexp(m, d, n);
      e.latency = int'(RST_CYCLES + lat);
      e.trig    = int'(lat);
    end else begin
      e.timeout = 1;
      e.latency = int'(RST_CYCLES + TIMEOUT);
      e.trig    = int'(TIMEOUT);
    end
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: per-cycle invariants plus scoreboard pop on each result handshake.
  int trig_cnt   = 0;
  int first_cyc  = 0;
  bit prev_valid = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      trig_cnt   = 0;
      prev_valid = 0;
    end else begin
      if (trigger) trig_cnt++;
      chk("trigger_vs_exp_reset", trigger, !exp_reset);
      chk("valid_ready_exclusive", out_valid && in_ready, 0);
      if (out_valid && !prev_valid) first_cyc = cyc;
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_result",  out_result,  e.result);
          chk("out_timeout", out_timeout, e.timeout);
          chk("out_error",   out_error,   e.error);
          chk("latency",     first_cyc - e.acc, e.latency);
          chk("trigger_cycles", trig_cnt, e.trig);
        end
        trig_cnt = 0;
      end
    end
  end

  // Offer a job and wait (bounded) for it to be accepted; acc is the accept edge.
  task automatic issue(input logic [31:0] m, input logic [31:0] d, input logic [31:0] n,
                       input int unsigned lat, output int acc);
    int guard = 0;
    @(negedge clk);
    in_valid = 1; in_m = m; in_d = d; in_n = n;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("accept_wait", 0, 1);
      in_valid = 0;
      acc = -1;
      return;
    end
    core_lat = lat;
    acc = cyc + 1;
    sb.push_back(model(m, d, n, lat, acc));
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_exp_reset"},  exp_reset,  1);
    chk({tag, "_in_ready"},   in_ready,   1);
    chk({tag, "_out_valid"},  out_valid,  0);
    chk({tag, "_trigger"},    trigger,    0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_out_result"}, out_result, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, acc2, hs;
    logic [31:0] m, d, n;
    int unsigned sel;
    reset = 0; in_valid = 0; in_m = 0; in_d = 0; in_n = 0; out_ready = 1;

    // Reset state, held for 5 cycles then released.
    repeat (5) begin
      @(negedge clk);
      check_idle("reset");
      chk("reset_exp_m", exp_m, 0);
    end
    reset = 1;
    @(negedge clk);
    check_idle("post_reset");

    // Back-to-back directed jobs.
    issue(6, 3, 9, 7, acc);
    issue(8, 7, 13, 9, acc);
    issue(63, 3, 17, 5, acc);
    issue(89, 5, 19, 11, acc);
    drain();

    // Backpressure: second job waits until the first result is taken.
    out_ready = 0;
    issue(8, 7, 13, 6, acc);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    chk("bp_first_valid", out_valid, 1);
    hs = 0;
    fork
      issue(63, 3, 17, 8, acc2);
      begin
        repeat (10) begin
          @(negedge clk);
          chk("bp_hold_valid",  out_valid,  1);
          chk("bp_hold_result", out_result, 5);
          chk("bp_in_ready",    in_ready,   0);
        end
        @(posedge clk);
        #1 out_ready = 1;
        hs = cyc + 1;
      end
    join
    chk("bp_accept_edge", acc2, hs + 1);
    drain();

    // Timeout, done-on-last-cycle boundary, one past it.
    issue(100, 200, 301, 1000, acc);
    issue(7, 11, 23, TIMEOUT, acc);
    issue(7, 11, 23, TIMEOUT + 1, acc);
    drain();

    // Modulus boundaries: zero is an error, one bypasses the core.
    issue(5, 3, 0, 3, acc);
    issue(5, 3, 1, 3, acc);
    drain();

    // Reset in the middle of RUN aborts the job.
    issue(89, 5, 19, 12, acc);
    for (int i = 0; i < 50 && !trigger; i++) @(negedge clk);
    chk("abort_reached_run", trigger, 1);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    sb.delete();
    #1 check_idle("abort");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1;
    issue(89, 5, 19, 9, acc);
    drain();

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      sel = $urandom_range(0, 9);
      m = $urandom; d = $urandom;
      if (sel == 0)      n = 0;
      else if (sel == 1) n = 1;
      else if (sel < 5)  n = $urandom_range(2, 1000);
      else begin
        n = $urandom;
        if (n < 2) n = 2;
      end
      issue(m, d, n, $urandom_range(1, TIMEOUT + 3), acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
